// File: rtl/dram_pkg.sv
// Request-word layout and scheduler defaults, shared between the request scheduler and dram_ctrl.
package dram_pkg;

   localparam int unsigned RW_BIT   = 13;
   localparam int unsigned BANK_MSB = 12;
   localparam int unsigned BANK_LSB = 10;
   localparam int unsigned ROW_MSB  = 9;
   localparam int unsigned ROW_LSB  = 3;
   localparam int unsigned COL_MSB  = 2;
   localparam int unsigned COL_LSB  = 0;

   localparam int unsigned DRAM_REQ_WIDTH       = RW_BIT + 1;
   localparam int unsigned STARVE_LIMIT_DEFAULT = 15;

   typedef struct packed {
      logic                       rw;
      logic [BANK_MSB-BANK_LSB:0] bank;
      logic [ROW_MSB-ROW_LSB:0]   row;
      logic [COL_MSB-COL_LSB:0]   col;
   } dram_req_t;

endpackage

// File: rtl/dram_req_sched_if.sv
// L2-lane request bus plus the scheduled-request port toward dram_ctrl.
interface dram_req_sched_if #(
   parameter int unsigned L2_REQ_WIDTH    = 14,
   parameter int unsigned DATA_WIDTH      = 1,
   parameter int unsigned NUMBER_OF_REQ   = 8,
   parameter int unsigned NUMBER_OF_BANKS = 8
);
   localparam int unsigned ID_WIDTH = $clog2(NUMBER_OF_REQ);

   logic [NUMBER_OF_REQ-1:0]              req_valid;
   logic [NUMBER_OF_REQ*L2_REQ_WIDTH-1:0] req_bus;
   logic [NUMBER_OF_REQ*DATA_WIDTH-1:0]   req_wdata;
   logic [NUMBER_OF_REQ-1:0]              req_ready;
   logic                                  sel_valid;
   logic [L2_REQ_WIDTH-1:0]               sel_req;
   logic [DATA_WIDTH-1:0]                 sel_wdata;
   logic [ID_WIDTH-1:0]                   sel_id;
   logic                                  sel_row_hit;
   logic                                  sel_ready;
   logic [NUMBER_OF_BANKS-1:0]            precharge_done;

   modport master (
      input  req_valid, req_bus, req_wdata, sel_ready, precharge_done,
      output req_ready, sel_valid, sel_req, sel_wdata, sel_id, sel_row_hit
   );

   modport slave (
      output req_valid, req_bus, req_wdata, sel_ready, precharge_done,
      input  req_ready, sel_valid, sel_req, sel_wdata, sel_id, sel_row_hit
   );

endinterface

// File: rtl/dram_req_sched_rr_pick.sv
// N-wide round-robin picker: first set mask bit at or after ptr, wrapping.
module rr_pick #(
   parameter  int unsigned N  = 8,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int unsigned j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!any && mask[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/dram_req_sched.sv
// Per-lane holding registers feeding a registered output; picks starved > row-hit > any, round-robin within class.
module dram_req_sched
   import dram_pkg::*;
#(
   parameter int unsigned L2_REQ_WIDTH    = DRAM_REQ_WIDTH,
   parameter int unsigned DATA_WIDTH      = 1,
   parameter int unsigned NUMBER_OF_REQ   = 8,
   parameter int unsigned NUMBER_OF_BANKS = 8,
   parameter int unsigned STARVE_LIMIT    = STARVE_LIMIT_DEFAULT
) (
   input logic              clk,
   input logic              rst_b,
   dram_req_sched_if.master bus
);

   localparam int unsigned IW = $clog2(NUMBER_OF_REQ);

   logic [NUMBER_OF_REQ-1:0] full, hit, starved;
   logic [3:0]               age       [NUMBER_OF_REQ];
   logic [L2_REQ_WIDTH-1:0]  ent_req   [NUMBER_OF_REQ];
   logic [DATA_WIDTH-1:0]    ent_wdata [NUMBER_OF_REQ];
   logic [IW-1:0]            rr_ptr;

   logic [NUMBER_OF_BANKS-1:0] row_open;
   logic [ROW_MSB-ROW_LSB:0]   open_row [NUMBER_OF_BANKS];

   logic [NUMBER_OF_REQ-1:0] starve_grant, hit_grant, all_grant, win_grant;
   logic [IW-1:0]            starve_idx, hit_idx, all_idx, win_idx;
   logic                     starve_any, hit_any, all_any, do_load;
   logic                     issue;
   logic [BANK_MSB-BANK_LSB:0] issue_bank;

   always_comb bus.req_ready = ~full;

   // Hit status uses the row table as it stands before this cycle's issue updates it.
   always_comb begin
      hit     = '0;
      starved = '0;
      for (int unsigned i = 0; i < NUMBER_OF_REQ; i++) begin
         hit[i] = full[i] && row_open[ent_req[i][BANK_MSB:BANK_LSB]] &&
                  (open_row[ent_req[i][BANK_MSB:BANK_LSB]] == ent_req[i][ROW_MSB:ROW_LSB]);
         starved[i] = full[i] && (32'(age[i]) >= STARVE_LIMIT);
      end
   end

   rr_pick #(.N(NUMBER_OF_REQ)) u_pick_starve (
      .mask(starved), .ptr(rr_ptr), .grant(starve_grant), .idx(starve_idx), .any(starve_any)
   );
   rr_pick #(.N(NUMBER_OF_REQ)) u_pick_hit (
      .mask(hit), .ptr(rr_ptr), .grant(hit_grant), .idx(hit_idx), .any(hit_any)
   );
   rr_pick #(.N(NUMBER_OF_REQ)) u_pick_all (
      .mask(full), .ptr(rr_ptr), .grant(all_grant), .idx(all_idx), .any(all_any)
   );

   always_comb begin
      win_grant = all_grant;
      win_idx   = all_idx;
      if (starve_any) begin
         win_grant = starve_grant;
         win_idx   = starve_idx;
      end else if (hit_any) begin
         win_grant = hit_grant;
         win_idx   = hit_idx;
      end
      do_load    = (!bus.sel_valid || bus.sel_ready) && all_any;
      issue      = bus.sel_valid && bus.sel_ready;
      issue_bank = bus.sel_req[BANK_MSB:BANK_LSB];
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         full <= '0;
         for (int unsigned i = 0; i < NUMBER_OF_REQ; i++) begin
            age[i]       <= '0;
            ent_req[i]   <= '0;
            ent_wdata[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUMBER_OF_REQ; i++) begin
            if (bus.req_valid[i] && !full[i]) begin
               full[i]      <= 1'b1;
               age[i]       <= '0;
               ent_req[i]   <= bus.req_bus[i*L2_REQ_WIDTH +: L2_REQ_WIDTH];
               ent_wdata[i] <= bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (full[i]) begin
               if (do_load && win_grant[i]) full[i] <= 1'b0;
               else if (age[i] != 4'hF)     age[i]  <= age[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         bus.sel_valid   <= 1'b0;
         bus.sel_req     <= '0;
         bus.sel_wdata   <= '0;
         bus.sel_id      <= '0;
         bus.sel_row_hit <= 1'b0;
         rr_ptr          <= '0;
      end else if (do_load) begin
         bus.sel_valid   <= 1'b1;
         bus.sel_req     <= ent_req[win_idx];
         bus.sel_wdata   <= ent_wdata[win_idx];
         bus.sel_id      <= win_idx;
         bus.sel_row_hit <= hit[win_idx];
         if (32'(win_idx) == NUMBER_OF_REQ - 1) rr_ptr <= '0;
         else                                   rr_ptr <= win_idx + 1'b1;
      end else if (bus.sel_ready) begin
         bus.sel_valid <= 1'b0;
      end
   end

   // An issue to a bank takes precedence over a same-cycle precharge of that bank.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         row_open <= '0;
         for (int unsigned b = 0; b < NUMBER_OF_BANKS; b++) open_row[b] <= '0;
      end else begin
         for (int unsigned b = 0; b < NUMBER_OF_BANKS; b++) begin
            if (issue && (32'(issue_bank) == b)) begin
               row_open[b] <= 1'b1;
               open_row[b] <= bus.sel_req[ROW_MSB:ROW_LSB];
            end else if (bus.precharge_done[b]) begin
               row_open[b] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dram_req_sched.sv
// Bench for dram_req_sched: directed scenarios plus randomized traffic against a lane/row-table reference model.
module tb_dram_req_sched;
   import dram_pkg::*;

   localparam int unsigned NR = 8;
   localparam int unsigned NB = 8;
   localparam int unsigned W  = 14;
   localparam int unsigned DW = 1;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   int   checks = 0;
   int   errors = 0;

   dram_req_sched_if #(.L2_REQ_WIDTH(W), .DATA_WIDTH(DW), .NUMBER_OF_REQ(NR), .NUMBER_OF_BANKS(NB)) bus ();

   dram_req_sched #(
      .L2_REQ_WIDTH(W), .DATA_WIDTH(DW), .NUMBER_OF_REQ(NR), .NUMBER_OF_BANKS(NB), .STARVE_LIMIT(15)
   ) dut (
      .clk(clk), .rst_b(rst_b), .bus(bus.master)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit          m_full [8];
   int          m_age  [8];
   logic [13:0] m_req  [8];
   logic        m_wd   [8];
   int          m_rr;
   bit          m_open [8];
   int          m_orow [8];
   logic        m_sel_valid;
   logic [13:0] m_sel_req;
   logic        m_sel_wd;
   int          m_sel_id;
   logic        m_sel_hit;

   function automatic logic [13:0] mk(int rw, int bank, int row, int col);
      dram_req_t r;
      r.rw   = 1'(rw);
      r.bank = 3'(bank);
      r.row  = 7'(row);
      r.col  = 3'(col);
      return r;
   endfunction

   function automatic int first_of(input bit c[8]);
      for (int k = 0; k < 8; k++) if (c[(m_rr + k) % 8]) return (m_rr + k) % 8;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_full[i] = 0; m_age[i] = 0; m_req[i] = '0; m_wd[i] = 0;
         m_open[i] = 0; m_orow[i] = 0;
      end
      m_rr = 0; m_sel_valid = 0; m_sel_req = '0; m_sel_wd = 0; m_sel_id = 0; m_sel_hit = 0;
   endtask

   task automatic ref_step();
      bit fl[8], ht[8], st[8];
      int win, ib, ir;
      bit load, iss;
      dram_req_t r;
      for (int i = 0; i < 8; i++) begin
         r     = m_req[i];
         fl[i] = m_full[i];
         ht[i] = m_full[i] && m_open[r.bank] && (m_orow[r.bank] == int'(r.row));
         st[i] = m_full[i] && (m_age[i] >= 15);
      end
      load = !m_sel_valid || bus.sel_ready;
      win  = -1;
      if (load) begin
         win = first_of(st);
         if (win < 0) win = first_of(ht);
         if (win < 0) win = first_of(fl);
      end
      iss = m_sel_valid && bus.sel_ready;
      r   = m_sel_req;
      ib  = int'(r.bank);
      ir  = int'(r.row);
      for (int i = 0; i < 8; i++)
         if (fl[i] && i != win) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
      for (int i = 0; i < 8; i++)
         if (bus.req_valid[i] && !fl[i]) begin
            m_full[i] = 1; m_age[i] = 0;
            m_req[i]  = bus.req_bus[i*14 +: 14];
            m_wd[i]   = bus.req_wdata[i];
         end
      if (win >= 0) begin
         m_sel_valid = 1; m_sel_req = m_req[win]; m_sel_wd = m_wd[win];
         m_sel_id = win; m_sel_hit = ht[win]; m_full[win] = 0; m_rr = (win + 1) % 8;
      end else if (bus.sel_ready) begin
         m_sel_valid = 0;
      end
      for (int b = 0; b < 8; b++) begin
         if (iss && ib == b) begin m_open[b] = 1; m_orow[b] = ir; end
         else if (bus.precharge_done[b]) m_open[b] = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_b) model_reset();
      else        ref_step();
      #1;
   endtask

   task automatic set_lane(int i, logic [13:0] r, logic wd);
      bus.req_bus[i*14 +: 14] = r;
      bus.req_wdata[i]        = wd;
   endtask

   task automatic apply_reset();
      rst_b = 1'b0;
      bus.req_valid = '0; bus.sel_ready = 1'b0; bus.precharge_done = '0;
      tick(); tick();
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      tick();
      checks++; if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL reset_sel_valid got %0b want 0", bus.sel_valid); end
      checks++; if (bus.sel_req !== 14'h0) begin errors++; $display("FAIL reset_sel_req got %h want 0", bus.sel_req); end
      checks++; if (bus.sel_wdata !== 1'b0) begin errors++; $display("FAIL reset_sel_wdata got %0b want 0", bus.sel_wdata); end
      checks++; if (bus.sel_id !== 3'd0) begin errors++; $display("FAIL reset_sel_id got %0d want 0", bus.sel_id); end
      checks++; if (bus.sel_row_hit !== 1'b0) begin errors++; $display("FAIL reset_row_hit got %0b want 0", bus.sel_row_hit); end
      checks++; if (bus.req_ready !== 8'hFF) begin errors++; $display("FAIL reset_req_ready got %h want ff", bus.req_ready); end
      rst_b = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      bus.sel_ready = 1'b1;
      set_lane(3, 14'h0A5B, 1'b1);
      bus.req_valid = 8'h08;
      tick();
      bus.req_valid = '0;
      checks++; if (bus.req_ready[3] !== 1'b0) begin errors++; $display("FAIL single_ready_low got %0b want 0", bus.req_ready[3]); end
      checks++; if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL single_latency got %0b want 0", bus.sel_valid); end
      tick();
      checks++; if (bus.sel_valid !== 1'b1 || bus.sel_id !== 3'd3) begin errors++; $display("FAIL single_sel got valid=%0b id=%0d want 1/3", bus.sel_valid, bus.sel_id); end
      checks++; if (bus.sel_req !== 14'h0A5B || bus.sel_wdata !== 1'b1) begin errors++; $display("FAIL single_data got %h/%0b want 0a5b/1", bus.sel_req, bus.sel_wdata); end
      checks++; if (bus.sel_row_hit !== 1'b0) begin errors++; $display("FAIL single_row_hit got %0b want 0", bus.sel_row_hit); end
      checks++; if (bus.req_ready[3] !== 1'b1) begin errors++; $display("FAIL single_ready_back got %0b want 1", bus.req_ready[3]); end
      tick();
      checks++; if (bus.sel_valid !== 1'b0 || bus.sel_req !== 14'h0A5B) begin errors++; $display("FAIL single_drain got valid=%0b req=%h want 0/0a5b", bus.sel_valid, bus.sel_req); end
   endtask

   task automatic test_round_robin();
      apply_reset();
      bus.sel_ready = 1'b1;
      for (int i = 0; i < 8; i++) set_lane(i, mk(0, i, $urandom_range(0, 127), i), 1'($urandom_range(0, 1)));
      bus.req_valid = 8'hFF;
      tick();
      bus.req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (bus.sel_valid !== 1'b1 || bus.sel_id !== 3'(k) || bus.sel_row_hit !== 1'b0)
            begin errors++; $display("FAIL rr_order got valid=%0b id=%0d hit=%0b want 1/%0d/0", bus.sel_valid, bus.sel_id, bus.sel_row_hit, k); end
      end
   endtask

   task automatic test_row_hit();
      apply_reset();
      bus.sel_ready = 1'b1;
      set_lane(0, mk(0, 1, 5, 0), 1'b0);
      bus.req_valid = 8'h01;
      tick();
      bus.req_valid = '0;
      tick();
      checks++; if (bus.sel_id !== 3'd0 || bus.sel_valid !== 1'b1) begin errors++; $display("FAIL hit_opener got id=%0d want 0", bus.sel_id); end
      set_lane(1, mk(0, 1, 9, 1), 1'b0);
      set_lane(2, mk(1, 1, 5, 2), 1'b1);
      bus.req_valid = 8'h06;
      tick();
      bus.req_valid = '0;
      tick();
      checks++; if (bus.sel_id !== 3'd2 || bus.sel_row_hit !== 1'b1) begin errors++; $display("FAIL hit_first got id=%0d hit=%0b want 2/1", bus.sel_id, bus.sel_row_hit); end
      tick();
      checks++; if (bus.sel_id !== 3'd1 || bus.sel_row_hit !== 1'b0) begin errors++; $display("FAIL hit_second got id=%0d hit=%0b want 1/0", bus.sel_id, bus.sel_row_hit); end
   endtask

   task automatic test_starvation();
      int found;
      apply_reset();
      bus.sel_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_lane(i, mk(0, 0, 1, i), 1'b0);
      bus.req_valid = 8'h0F;
      tick(); tick(); tick();
      set_lane(4, mk(0, 0, 2, 4), 1'b1);
      bus.req_valid = 8'h1F;
      tick();
      bus.req_valid = 8'h0F;
      checks++; if (bus.req_ready[4] !== 1'b0) begin errors++; $display("FAIL starve_capture got %0b want 0", bus.req_ready[4]); end
      found = 0;
      for (int n = 1; n <= 16; n++) begin
         tick();
         if (found == 0 && bus.sel_valid === 1'b1 && bus.sel_id === 3'd4) found = n;
         checks++; if (bus.sel_id !== 3'(m_sel_id)) begin errors++; $display("FAIL starve_model_id got %0d want %0d", bus.sel_id, m_sel_id); end
      end
      checks++; if (found != 16) begin errors++; $display("FAIL starve_cycle got %0d want 16", found); end
      checks++; if (bus.sel_row_hit !== 1'b0) begin errors++; $display("FAIL starve_row_hit got %0b want 0", bus.sel_row_hit); end
      bus.req_valid = '0;
      tick(); tick(); tick();
   endtask

   task automatic test_backpressure();
      apply_reset();
      bus.sel_ready = 1'b0;
      for (int i = 0; i < 3; i++) set_lane(i, mk(0, i + 3, i, 0), 1'(i));
      bus.req_valid = 8'h07;
      tick();
      bus.req_valid = '0;
      tick();
      checks++; if (bus.sel_valid !== 1'b1 || bus.sel_id !== 3'd0) begin errors++; $display("FAIL bp_first got valid=%0b id=%0d want 1/0", bus.sel_valid, bus.sel_id); end
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if (bus.sel_valid !== 1'b1 || bus.sel_id !== 3'd0 || bus.sel_req !== mk(0, 3, 0, 0) ||
             bus.sel_wdata !== 1'b0 || bus.sel_row_hit !== 1'b0 || bus.req_ready !== 8'hF9)
            begin errors++; $display("FAIL bp_hold got v=%0b id=%0d req=%h rdy=%h want 1/0/%h/f9", bus.sel_valid, bus.sel_id, bus.sel_req, bus.req_ready, mk(0, 3, 0, 0)); end
      end
      bus.sel_ready = 1'b1;
      tick();
      checks++; if (bus.sel_id !== 3'd1 || bus.sel_wdata !== 1'b1) begin errors++; $display("FAIL bp_resume1 got id=%0d want 1", bus.sel_id); end
      tick();
      checks++; if (bus.sel_id !== 3'd2 || bus.sel_valid !== 1'b1) begin errors++; $display("FAIL bp_resume2 got id=%0d want 2", bus.sel_id); end
      tick();
      checks++; if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", bus.sel_valid); end
   endtask

   task automatic test_precharge_reset();
      apply_reset();
      bus.sel_ready = 1'b1;
      set_lane(0, mk(0, 2, 7, 0), 1'b0);
      bus.req_valid = 8'h01;
      tick();
      bus.req_valid = '0;
      tick();
      bus.precharge_done = 8'h04;
      tick();
      bus.precharge_done = '0;
      set_lane(1, mk(1, 2, 7, 1), 1'b1);
      bus.req_valid = 8'h02;
      tick();
      bus.req_valid = '0;
      tick();
      checks++; if (bus.sel_id !== 3'd1 || bus.sel_row_hit !== 1'b1) begin errors++; $display("FAIL pc_collision got id=%0d hit=%0b want 1/1", bus.sel_id, bus.sel_row_hit); end
      tick();
      bus.precharge_done = 8'h04;
      tick();
      bus.precharge_done = '0;
      set_lane(2, mk(0, 2, 7, 2), 1'b0);
      bus.req_valid = 8'h04;
      tick();
      bus.req_valid = '0;
      tick();
      checks++; if (bus.sel_id !== 3'd2 || bus.sel_row_hit !== 1'b0) begin errors++; $display("FAIL pc_closed got id=%0d hit=%0b want 2/0", bus.sel_id, bus.sel_row_hit); end
      // Reset asserted between clock edges
      bus.sel_ready = 1'b0;
      for (int i = 0; i < 4; i++) set_lane(i, mk(0, i, $urandom_range(0, 127), 0), 1'b1);
      bus.req_valid = 8'h0F;
      tick(); tick();
      checks++; if (bus.sel_valid !== 1'b1 || bus.req_ready === 8'hFF) begin errors++; $display("FAIL areset_pre got v=%0b rdy=%h want 1/not ff", bus.sel_valid, bus.req_ready); end
      #2 rst_b = 1'b0;
      #1;
      model_reset();
      checks++; if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL areset_sel_valid got %0b want 0", bus.sel_valid); end
      checks++; if (bus.req_ready !== 8'hFF) begin errors++; $display("FAIL areset_req_ready got %h want ff", bus.req_ready); end
      bus.req_valid = '0;
      tick();
      rst_b = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] exp_rdy;
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.req_valid = 8'($urandom);
         for (int i = 0; i < 8; i++)
            set_lane(i, mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         bus.sel_ready = (cyc % 200 < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         for (int b = 0; b < 8; b++) bus.precharge_done[b] = ($urandom_range(0, 9) == 0);
         tick();
         for (int i = 0; i < 8; i++) exp_rdy[i] = !m_full[i];
         checks++; if (bus.sel_valid !== m_sel_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, bus.sel_valid, m_sel_valid); end
         checks++; if (bus.sel_req !== m_sel_req) begin errors++; $display("FAIL rnd_req cyc %0d got %h want %h", cyc, bus.sel_req, m_sel_req); end
         checks++; if (bus.sel_wdata !== m_sel_wd) begin errors++; $display("FAIL rnd_wdata cyc %0d got %0b want %0b", cyc, bus.sel_wdata, m_sel_wd); end
         checks++; if (bus.sel_id !== 3'(m_sel_id)) begin errors++; $display("FAIL rnd_id cyc %0d got %0d want %0d", cyc, bus.sel_id, m_sel_id); end
         checks++; if (bus.sel_row_hit !== m_sel_hit) begin errors++; $display("FAIL rnd_hit cyc %0d got %0b want %0b", cyc, bus.sel_row_hit, m_sel_hit); end
         checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %h want %h", cyc, bus.req_ready, exp_rdy); end
      end
   endtask

   initial begin
      bus.req_valid      = '0;
      bus.req_bus        = '0;
      bus.req_wdata      = '0;
      bus.sel_ready      = 1'b0;
      bus.precharge_done = '0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_row_hit();
      test_starvation();
      test_backpressure();
      test_precharge_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dram_req_sched.md
# dram_req_sched

Request scheduler that sits directly upstream of `dram_ctrl`. It collects read/write requests from the eight L2 requester lanes, holds one request per lane, and picks one per cycle. Selection prefers open-row hits, falls back to round-robin, and overrides both with a starvation guard. The chosen request is presented on a single registered valid/ready port, tagged with its lane id so responses can be routed back to the right L2 lane.

## Interface
- `L2_REQ_WIDTH`, 14, request word: [13]=rw (1=write), [12:10]=bank, [9:3]=row, [2:0]=col
- `DATA_WIDTH`, 1, write data width per lane
- `NUMBER_OF_REQ`, 8, requester lanes
- `NUMBER_OF_BANKS`, 8, DRAM banks
- `STARVE_LIMIT`, 15, wait cycles after which an entry becomes starved
- `clk`  in  1  single clock; all state on rising edge
- `rst_b`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUMBER_OF_REQ  per-lane request valid
- `req_bus`  in  NUMBER_OF_REQ*L2_REQ_WIDTH  lane i at [i*L2_REQ_WIDTH +: L2_REQ_WIDTH]
- `req_wdata`  in  NUMBER_OF_REQ*DATA_WIDTH  lane i write data
- `req_ready`  out  NUMBER_OF_REQ  lane holding register empty
- `sel_valid`  out  1  scheduled request valid
- `sel_req`  out  L2_REQ_WIDTH  scheduled request word
- `sel_wdata`  out  DATA_WIDTH  scheduled write data
- `sel_id`  out  $clog2(NUMBER_OF_REQ)  originating lane
- `sel_row_hit`  out  1  request targets the currently open row of its bank
- `sel_ready`  in  1  controller accepts the scheduled request
- `precharge_done`  in  NUMBER_OF_BANKS  one-cycle pulse: bank b row closed

## Operation
- **Lane holding registers.** Each lane has one register with a `full` flag and a 4-bit `age`.
  - `req_ready[i] = ~full[i]`, combinational from state only.
  - On `req_valid[i] & req_ready[i]`: capture `req_bus` and `req_wdata`, set `full`, clear `age`.
- **Row table.** Per bank: `row_open` (1 bit) and `open_row` (7 bits).
  - An entry is a *hit* if `full`, `row_open[bank]`, and `open_row[bank] == row`.
- **Load condition.** The output register loads when `~sel_valid | sel_ready`.
- **Winner selection** among full entries, in priority order:
  1. Starved entries (`age >= STARVE_LIMIT`).
  2. Hits.
  3. All full entries.
  - Within the chosen class, round-robin starting at `rr_ptr`.
- **On load:**
  - Clear the winner's `full`.
  - Set `rr_ptr <= winner+1`, wrapping modulo NUMBER_OF_REQ.
  - Set `sel_row_hit` from the hit status at selection time.
- **Aging.** Every full entry that is not the winner increments `age`, saturating at 15, in every cycle where any entry is full.
- **Row-table update on `sel_valid & sel_ready`.** `row_open[bank] <= 1`, `open_row[bank] <= row`.
  - If `precharge_done[b]` arrives in the same cycle for the same bank, the issue wins (row stays open with the new row).
  - If `precharge_done[b]` arrives alone, clear `row_open[b]`.
- **Hits are evaluated against the row table before that cycle's update.** A request already in the output register does not affect hit classification.
- **No full entries:** the output register empties on `sel_ready`.
  - `sel_valid` goes to 0.
  - `sel_req`, `sel_wdata` and `sel_id` hold their last values.
- **Reset mid-operation:** all pending requests are dropped; the L2 side must reissue them.

## Timing
- **Reset values:**
  - Outputs: `sel_valid`=0, `sel_req`=0, `sel_wdata`=0, `sel_id`=0, `sel_row_hit`=0, `req_ready`=all ones (all registers empty).
  - Internal state: `rr_ptr`=0, all `row_open`=0, all `age`=0.
- **Latency:** a request captured at edge N can appear on `sel_*` at edge N+1 at the earliest. The output is registered; there is no combinational input-to-`sel_*` path.
- **Per-lane throughput:** one request per 2 cycles. `req_ready` rises the cycle after the entry is selected.
- **Aggregate throughput:** one request per cycle while `sel_ready` is held at 1.
- **Output hold:** while `sel_valid & ~sel_ready`, all `sel_*` outputs stay stable and no loading occurs. Ages still increment during this stall.

## Structure
- **Shared package `dram_pkg`** holds:
  - Field offsets and widths: `RW_BIT`, `BANK_MSB`/`LSB`, `ROW_MSB`/`LSB`, `COL_MSB`/`LSB`.
  - Request typedef `dram_req_t`.
  - `STARVE_LIMIT` default.
  - The package is shared with `dram_ctrl`.
- **One sub-module, `rr_pick`:** parameterised N-wide round-robin priority picker.
  - Inputs: mask, pointer.
  - Outputs: one-hot grant plus index.
  - Instantiated three times (starved, hit, all); a mux selects the non-empty class in priority order.

## Test plan
- **Reset then single request:** lane 3 presents `14'h0A5B` (read, bank 2, row 0x4B, col 3). At the next edge `sel_valid`=1, `sel_id`=3, `sel_row_hit`=0. `req_ready[3]`=0 for one cycle.
- **Round-robin:** all 8 lanes full with distinct banks, no open rows, `sel_ready`=1. `sel_id` sequence is 0,1,...,7 from `rr_ptr`=0.
- **Row-hit priority:** issue lane 0 to bank 1 row 5. Then lanes 1 (bank 1 row 9) and 2 (bank 1 row 5) are both full with `rr_ptr`=1. Lane 2 is selected first with `sel_row_hit`=1; lane 1 follows.
- **Starvation:** lane 4 holds a miss while lanes 0–3 stream hits to an open row. Once lane 4's `age` reaches 15, it is selected on the next load regardless of hits.
- **Backpressure:** hold `sel_ready`=0 for 5 cycles with lanes 0–2 full. The `sel_*` outputs stay constant and no lane's `req_ready` rises. Releasing `sel_ready` resumes selection.
- **Precharge collision and async reset:**
  - Assert `precharge_done[2]` in the same cycle as an issue to bank 2 row 7: `row_open[2]` stays 1. A follow-up request to bank 2 row 7 reports `sel_row_hit`=1.
  - Assert `rst_b`=0 mid-stream: `sel_valid` drops immediately and `req_ready`=8'hFF.
